// File: rtl/ecc_ctrl_pkg.sv
// Shared types for the ECC SRAM scrub controller: FSM states and op source.
package ecc_ctrl_pkg;

   // Port sequencing: IDLE -> ACCESS -> CHECK -> (FIX) -> IDLE.
   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StCheck,
      StFix
   } ctrl_state_e;

   // Who owns the op currently in flight.
   typedef enum logic {
      SrcBus,
      SrcScrub
   } op_src_e;

endpackage

// File: rtl/sram_scrub_timer.sv
// Scrub pacing: interval countdown, scrub_due flag, bus-defer counter, scrub address and wrap
// pulse. The controller only tells it when a scrub is issued, when one finishes and when the bus
// won arbitration.
module sram_scrub_timer #(
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned SCRUB_INTERVAL = 1024,
   parameter int unsigned MAX_DEFER      = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  scrub_enable_i,
   input  logic                  bus_accept_i,
   input  logic                  scrub_issue_i,
   input  logic                  scrub_done_i,
   output logic                  scrub_due_o,
   output logic                  defer_max_o,
   output logic [ADDR_WIDTH-1:0] scrub_addr_o,
   output logic                  scrub_wrap_o
);

   localparam int unsigned TimerW = $clog2(SCRUB_INTERVAL + 1);
   localparam int unsigned DeferW = $clog2(MAX_DEFER + 1);
   localparam logic [TimerW-1:0] TimerLoad = TimerW'(SCRUB_INTERVAL);
   localparam logic [DeferW-1:0] DeferMax  = DeferW'(MAX_DEFER);

   logic [TimerW-1:0]     timer_q, timer_d;
   logic [DeferW-1:0]     defer_q, defer_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  due_q, due_d;
   logic                  wrap_q, wrap_d;
   logic                  expire;

   // Next-state for countdown, due flag, defer count and scrub address.
   always_comb begin
      timer_d = timer_q;
      expire  = 1'b0;
      // Expire on the step that would reach zero so the period is exactly SCRUB_INTERVAL.
      if (scrub_enable_i) begin
         if (timer_q == TimerW'(1)) begin
            expire  = 1'b1;
            timer_d = TimerLoad;
         end else begin
            timer_d = timer_q - TimerW'(1);
         end
      end

      // An expiry while a scrub is already pending is dropped, never queued.
      due_d = (due_q & ~scrub_issue_i) | (expire & ~due_q);

      defer_d = defer_q;
      if (scrub_issue_i) begin
         defer_d = '0;
      end else if (due_q && bus_accept_i && (defer_q != DeferMax)) begin
         defer_d = defer_q + DeferW'(1);
      end

      addr_d = addr_q;
      wrap_d = 1'b0;
      if (scrub_done_i) begin
         addr_d = addr_q + ADDR_WIDTH'(1);
         wrap_d = &addr_q;
      end
   end

   // Pacing state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         timer_q <= TimerLoad;
         defer_q <= '0;
         addr_q  <= '0;
         due_q   <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         timer_q <= timer_d;
         defer_q <= defer_d;
         addr_q  <= addr_d;
         due_q   <= due_d;
         wrap_q  <= wrap_d;
      end
   end

   assign scrub_due_o  = due_q;
   assign defer_max_o  = (defer_q == DeferMax);
   assign scrub_addr_o = addr_q;
   assign scrub_wrap_o = wrap_q;

endmodule

// File: rtl/sram_scrub_ctrl.sv
// Arbitrates the single ECC SRAM port between bus requests and a background scrubber, and writes
// back decoder-corrected words on correctable read errors. Optional build macro
// SCRUB_ERR_COUNTERS_EN adds saturating correctable/uncorrectable error counters.
module sram_scrub_ctrl
   import ecc_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned SCRUB_INTERVAL = 1024,
   parameter int unsigned MAX_DEFER      = 64,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_write_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  resp_valid_o,
   output logic [DATA_WIDTH-1:0] resp_rdata_o,
   output logic                  resp_error_o,
   output logic                  mem_clk_en_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic                  mem_write_en_o,
   output logic [DATA_WIDTH-1:0] mem_write_data_o,
   input  logic [DATA_WIDTH-1:0] mem_read_data_i,
   input  logic                  mem_error_i,
   input  logic                  mem_uncorrectable_i,
   input  logic                  scrub_enable_i,
   output logic                  scrub_wrap_o
`ifdef SCRUB_ERR_COUNTERS_EN
   ,
   output logic [CNT_WIDTH-1:0]  corr_count_o,
   output logic [CNT_WIDTH-1:0]  uncorr_count_o
`endif
);

   ctrl_state_e           state_q, state_d;
   op_src_e               src_q, src_d;
   logic                  op_write_q, op_write_d;
   logic [ADDR_WIDTH-1:0] op_addr_q, op_addr_d;
   logic                  init_q;

   logic                  mem_clk_en_q, mem_clk_en_d;
   logic                  mem_write_en_q, mem_write_en_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_write_data_q, mem_write_data_d;

   logic                  scrub_due, defer_max;
   logic [ADDR_WIDTH-1:0] scrub_addr;
   logic                  bus_accept, scrub_issue, scrub_done;
   logic                  check_read;

   sram_scrub_timer #(
      .ADDR_WIDTH     (ADDR_WIDTH),
      .SCRUB_INTERVAL (SCRUB_INTERVAL),
      .MAX_DEFER      (MAX_DEFER)
   ) u_timer (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .scrub_enable_i (scrub_enable_i),
      .bus_accept_i   (bus_accept),
      .scrub_issue_i  (scrub_issue),
      .scrub_done_i   (scrub_done),
      .scrub_due_o    (scrub_due),
      .defer_max_o    (defer_max),
      .scrub_addr_o   (scrub_addr),
      .scrub_wrap_o   (scrub_wrap_o)
   );

   // init_q keeps req_ready low while in reset so every output reads 0 there.
   assign req_ready_o = init_q && (state_q == StIdle) && !(scrub_due && defer_max);
   assign bus_accept  = req_valid_i && req_ready_o;
   assign check_read  = (state_q == StCheck) && !op_write_q;

   // FSM next state; mem_* strobes are computed one state early so they are registered outputs.
   always_comb begin
      state_d          = state_q;
      src_d            = src_q;
      op_write_d       = op_write_q;
      op_addr_d        = op_addr_q;
      mem_clk_en_d     = 1'b0;
      mem_write_en_d   = 1'b0;
      mem_addr_d       = mem_addr_q;
      mem_write_data_d = mem_write_data_q;
      scrub_issue      = 1'b0;
      scrub_done       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus_accept) begin
               src_d          = SrcBus;
               op_write_d     = req_write_i;
               op_addr_d      = req_addr_i;
               mem_clk_en_d   = 1'b1;
               mem_write_en_d = req_write_i;
               mem_addr_d     = req_addr_i;
               if (req_write_i) begin
                  mem_write_data_d = req_wdata_i;
               end
               state_d = StAccess;
            end else if (scrub_due) begin
               src_d        = SrcScrub;
               op_write_d   = 1'b0;
               op_addr_d    = scrub_addr;
               mem_clk_en_d = 1'b1;
               mem_addr_d   = scrub_addr;
               scrub_issue  = 1'b1;
               state_d      = StAccess;
            end
         end
         StAccess: begin
            state_d = StCheck;
         end
         StCheck: begin
            // Scrub advances even on an uncorrectable word; it is simply never written back.
            scrub_done = (src_q == SrcScrub);
            if (!op_write_q && mem_error_i && !mem_uncorrectable_i) begin
               mem_clk_en_d     = 1'b1;
               mem_write_en_d   = 1'b1;
               mem_addr_d       = op_addr_q;
               mem_write_data_d = mem_read_data_i;
               state_d          = StFix;
            end else begin
               state_d = StIdle;
            end
         end
         StFix: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // FSM, latched op and registered SRAM control.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q          <= StIdle;
         src_q            <= SrcBus;
         op_write_q       <= 1'b0;
         op_addr_q        <= '0;
         init_q           <= 1'b0;
         mem_clk_en_q     <= 1'b0;
         mem_write_en_q   <= 1'b0;
         mem_addr_q       <= '0;
         mem_write_data_q <= '0;
      end else begin
         state_q          <= state_d;
         src_q            <= src_d;
         op_write_q       <= op_write_d;
         op_addr_q        <= op_addr_d;
         init_q           <= 1'b1;
         mem_clk_en_q     <= mem_clk_en_d;
         mem_write_en_q   <= mem_write_en_d;
         mem_addr_q       <= mem_addr_d;
         mem_write_data_q <= mem_write_data_d;
      end
   end

   // Bus response is presented in CHECK, straight from the decoder.
   always_comb begin
      resp_valid_o = (state_q == StCheck) && (src_q == SrcBus);
      resp_rdata_o = '0;
      resp_error_o = 1'b0;
      if (resp_valid_o && !op_write_q) begin
         resp_rdata_o = mem_read_data_i;
         resp_error_o = mem_uncorrectable_i;
      end
   end

   assign mem_clk_en_o     = mem_clk_en_q;
   assign mem_addr_o       = mem_addr_q;
   assign mem_write_en_o   = mem_write_en_q;
   assign mem_write_data_o = mem_write_data_q;

`ifdef SCRUB_ERR_COUNTERS_EN
   logic [CNT_WIDTH-1:0] corr_q, corr_d, uncorr_q, uncorr_d;

   // Saturating error counters, bumped on every checked read (bus or scrub).
   always_comb begin
      corr_d   = corr_q;
      uncorr_d = uncorr_q;
      if (check_read && mem_uncorrectable_i && (uncorr_q != '1)) begin
         uncorr_d = uncorr_q + CNT_WIDTH'(1);
      end
      if (check_read && mem_error_i && !mem_uncorrectable_i && (corr_q != '1)) begin
         corr_d = corr_q + CNT_WIDTH'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         corr_q   <= '0;
         uncorr_q <= '0;
      end else begin
         corr_q   <= corr_d;
         uncorr_q <= uncorr_d;
      end
   end

   assign corr_count_o   = corr_q;
   assign uncorr_count_o = uncorr_q;
`else
   logic                 unused_check_read;
   logic [CNT_WIDTH-1:0] unused_cnt_width;
   assign unused_check_read = check_read;
   assign unused_cnt_width  = '0;
`endif

endmodule
